// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port big-endian data memory between
// the CPU path (A) and the loader/DMA path (B), one-cycle access phase.
//
// state  | meaning
// IDLE   | no memory activity, strobes inactive
// ACCESS | one cycle driving the memory from the captured request
module dmem_arbiter #(
  parameter int MEM_BYTES  = 301,
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic        a_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic        b_err,
  output logic [31:0] b_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_rd_n,
  output logic        mem_wr_n,
  input  logic [31:0] mem_dout,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;   // 0 = A, 1 = B
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rr_q, rr_d;         // 0 = A preferred on contention
  logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic        a_err_q, a_err_d, b_err_q, b_err_d;
  logic [31:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic completing, legal, a_elig, b_elig, win_b;

  assign completing = (state_q == ACCESS);
  assign legal      = (addr_q[1:0] == 2'b00) && (addr_q <= LAST_WORD);
  // The completing owner is masked so a held request costs one idle cycle.
  assign a_elig     = a_req && !(completing && !owner_q);
  assign b_elig     = b_req && !(completing && owner_q);
  assign win_b      = b_elig && (!a_elig || rr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rr_d    = rr_q;
    if (a_elig || b_elig) begin
      state_d = ACCESS;
      owner_d = win_b;
      we_d    = win_b ? b_we    : a_we;
      addr_d  = win_b ? b_addr  : a_addr;
      wdata_d = win_b ? b_wdata : a_wdata;
      if (a_elig && b_elig) rr_d = !rr_q;
    end
  end

  always_comb begin
    a_ack_d   = completing && !owner_q;
    b_ack_d   = completing && owner_q;
    a_err_d   = a_ack_d && !legal;
    b_err_d   = b_ack_d && !legal;
    a_rdata_d = (a_ack_d && legal && !we_q) ? mem_dout : a_rdata_q;
    b_rdata_d = (b_ack_d && legal && !we_q) ? mem_dout : b_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rr_q      <= PRIO_RESET;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rr_q      <= rr_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_err_q   <= a_err_d;
      b_err_q   <= b_err_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // Strobes decode straight from state so reset deasserts them asynchronously.
  always_comb begin
    busy     = (state_q == ACCESS);
    mem_rd_n = !(busy && legal && !we_q);
    mem_wr_n = !(busy && legal && we_q);
  end

  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_err    = a_err_q;
  assign b_err    = b_err_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: big-endian byte RAM model plus
// per-port queues of expected completions checked on every ack.
module tb_dmem_arbiter;

  logic        clk, rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_addr, mem_din;
  logic        mem_rd_n, mem_wr_n, busy;
  wire  [31:0] mem_dout;

  dmem_arbiter #(.MEM_BYTES(301), .PRIO_RESET(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd_n(mem_rd_n),
    .mem_wr_n(mem_wr_n), .mem_dout(mem_dout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram       [0:300];
  logic [7:0] model_mem [0:300];
  logic [31:0] rd_word;
  logic [8:0]  ix;

  always_comb begin
    rd_word = 32'h0;
    ix = mem_addr[8:0];
    if (mem_addr <= 32'd297)
      rd_word = {ram[ix], ram[ix + 9'd1], ram[ix + 9'd2], ram[ix + 9'd3]};
  end
  assign mem_dout = !mem_rd_n ? rd_word : 32'hzzzz_zzzz;

  always @(negedge clk) begin
    if (!mem_wr_n && mem_addr <= 32'd297) begin
      ram[mem_addr[8:0]]         <= mem_din[31:24];
      ram[mem_addr[8:0] + 9'd1]  <= mem_din[23:16];
      ram[mem_addr[8:0] + 9'd2]  <= mem_din[15:8];
      ram[mem_addr[8:0] + 9'd3]  <= mem_din[7:0];
    end
  end

  typedef struct {logic err; logic [31:0] rdata;} exp_t;
  exp_t qa[$], qb[$];
  logic [31:0] last_a, last_b;
  int checks = 0, passed = 0;

  task automatic push_exp(input bit pb, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    bit lg;
    lg = (addr[1:0] == 2'b00) && (addr <= 32'd297);
    e.err = !lg;
    e.rdata = pb ? last_b : last_a;
    if (lg && we) for (int i = 0; i < 4; i++) model_mem[addr + i] = wd[31 - 8*i -: 8];
    if (lg && !we) e.rdata = {model_mem[addr], model_mem[addr+1], model_mem[addr+2], model_mem[addr+3]};
    if (pb) begin last_b = e.rdata; qb.push_back(e); end
    else    begin last_a = e.rdata; qa.push_back(e); end
  endtask

  // Completion scoreboard: every ack must match the oldest expectation of its port.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (a_ack) begin
        checks++;
        if (qa.size() == 0) $display("FAIL a_unexpected_ack: got ack, expected none");
        else begin
          e = qa.pop_front();
          if (a_err !== e.err || a_rdata !== e.rdata)
            $display("FAIL a_completion: got err=%0b rdata=%h, expected err=%0b rdata=%h", a_err, a_rdata, e.err, e.rdata);
          else passed++;
        end
      end
      if (b_ack) begin
        checks++;
        if (qb.size() == 0) $display("FAIL b_unexpected_ack: got ack, expected none");
        else begin
          e = qb.pop_front();
          if (b_err !== e.err || b_rdata !== e.rdata)
            $display("FAIL b_completion: got err=%0b rdata=%h, expected err=%0b rdata=%h", b_err, b_rdata, e.err, e.rdata);
          else passed++;
        end
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    qa.delete(); qb.delete();
    last_a = 0; last_b = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic single_xfer(input bit pb, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    bit lg;
    lg = (addr[1:0] == 2'b00) && (addr <= 32'd297);
    @(negedge clk);
    if (pb) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else    begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    push_exp(pb, we, addr, wd);
    @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL xfer_busy: got %0b expected 1", busy); else passed++;
    checks++; if (mem_rd_n !== !(lg && !we)) $display("FAIL xfer_rd_n @%h: got %0b expected %0b", addr, mem_rd_n, !(lg && !we)); else passed++;
    checks++; if (mem_wr_n !== !(lg && we)) $display("FAIL xfer_wr_n @%h: got %0b expected %0b", addr, mem_wr_n, !(lg && we)); else passed++;
    checks++; if (mem_addr !== addr) $display("FAIL xfer_mem_addr: got %h expected %h", mem_addr, addr); else passed++;
    if (lg && we) begin
      checks++; if (mem_din !== wd) $display("FAIL xfer_mem_din: got %h expected %h", mem_din, wd); else passed++;
    end
    @(negedge clk);
    checks++; if ((pb ? b_ack : a_ack) !== 1'b1) $display("FAIL xfer_ack: got 0 expected 1"); else passed++;
    a_req = 0; b_req = 0;
    @(negedge clk);
    checks++; if ((pb ? b_ack : a_ack) !== 1'b0) $display("FAIL xfer_ack_width: got 1 expected 0"); else passed++;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (mem_rd_n !== 1'b1 || mem_wr_n !== 1'b1) $display("FAIL reset_strobes: got %0b%0b expected 11", mem_rd_n, mem_wr_n); else passed++;
    checks++; if (mem_addr !== 32'h0 || mem_din !== 32'h0) $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_din); else passed++;
    checks++; if ({a_ack, b_ack, a_err, b_err, busy} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {a_ack, b_ack, a_err, b_err, busy}); else passed++;
    checks++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) $display("FAIL reset_rdata: got %h/%h expected 0/0", a_rdata, b_rdata); else passed++;
  endtask

  task automatic test_write_read();
    single_xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    single_xfer(1'b0, 1'b0, 32'h10, 32'h0);
    checks++; if (a_rdata !== 32'hDEADBEEF) $display("FAIL write_read_data: got %h expected deadbeef", a_rdata); else passed++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 32'h10;
    b_req = 1; b_we = 0; b_addr = 32'h40;
    push_exp(1'b0, 1'b0, 32'h10, 32'h0); push_exp(1'b1, 1'b0, 32'h40, 32'h0);
    push_exp(1'b0, 1'b0, 32'h10, 32'h0); push_exp(1'b1, 1'b0, 32'h40, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b1 || mem_rd_n !== 1'b0) $display("FAIL b2b_busy k=%0d: got busy=%0b rd_n=%0b expected 1/0", k, busy, mem_rd_n); else passed++;
      checks++; if (mem_addr !== ((k % 2) ? 32'h10 : 32'h40)) $display("FAIL b2b_grant k=%0d: got %h expected %h", k, mem_addr, (k % 2) ? 32'h10 : 32'h40); else passed++;
      if (k == 4) begin a_req = 0; b_req = 0; end
    end
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || qa.size() != 0 || qb.size() != 0) $display("FAIL b2b_drain: got busy=%0b pending=%0d/%0d expected 0/0/0", busy, qa.size(), qb.size()); else passed++;
  endtask

  task automatic test_single_hold();
    int acks = 0;
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 32'h20;
    repeat (3) push_exp(1'b0, 1'b0, 32'h20, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (a_ack) acks++;
      checks++; if (busy !== bit'(k % 2) || a_ack !== !bit'(k % 2)) $display("FAIL hold_pattern k=%0d: got busy=%0b ack=%0b expected %0b/%0b", k, busy, a_ack, k % 2, !(k % 2)); else passed++;
    end
    a_req = 0;
    @(negedge clk);
    checks++; if (acks != 3 || busy !== 1'b0) $display("FAIL hold_count: got acks=%0d busy=%0b expected 3/0", acks, busy); else passed++;
  endtask

  task automatic test_last_word();
    single_xfer(1'b1, 1'b0, 32'h11C, 32'h0);
    single_xfer(1'b1, 1'b0, 32'h128, 32'h0);
  endtask

  task automatic test_illegal();
    single_xfer(1'b0, 1'b0, 32'h13, 32'h0);
    single_xfer(1'b1, 1'b0, 32'h12C, 32'h0);
    single_xfer(1'b1, 1'b1, 32'h12C, 32'h0BADF00D);
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    b_req = 1; b_we = 1; b_addr = 32'h20; b_wdata = 32'h12345678;
    @(posedge clk);
    #2;
    rst_n = 0; b_req = 0;
    #1;
    checks++; if (mem_wr_n !== 1'b1 || busy !== 1'b0) $display("FAIL rst_mid_strobe: got wr_n=%0b busy=%0b expected 1/0", mem_wr_n, busy); else passed++;
    @(negedge clk);
    @(negedge clk);
    qa.delete(); qb.delete(); last_a = 0; last_b = 0;
    rst_n = 1;
    for (int i = 32; i < 36; i++) begin
      checks++; if (ram[i] !== model_mem[i]) $display("FAIL rst_mid_ram[%0d]: got %h expected %h", i, ram[i], model_mem[i]); else passed++;
    end
    a_req = 1; a_we = 0; a_addr = 32'h40;
    b_req = 1; b_we = 0; b_addr = 32'h44;
    push_exp(1'b0, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    checks++; if (mem_addr !== 32'h40) $display("FAIL rst_mid_rr: got %h expected 00000040", mem_addr); else passed++;
    a_req = 0; b_req = 0;
    repeat (3) @(negedge clk);
    checks++; if (qa.size() != 0) $display("FAIL rst_mid_pending: got %0d expected 0", qa.size()); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 301; i++) begin
      ram[i] = 8'(i) ^ 8'hA5;
      model_mem[i] = 8'(i) ^ 8'hA5;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_single_hold();
    test_last_word();
    test_illegal();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
